key_scan: RTL and testbench

KEY_SCAN -- requirements
Module: key_scan

---
 rtl/key_scan_pkg.sv | 7 +
 rtl/key_scan_if.sv | 21 ++
 rtl/key_scan_rr_arbiter.sv | 22 ++
 rtl/key_scan.sv | 72 +++++++
 tb/tb_key_scan.sv | 135 +++++++++++++
 5 files changed

// File: rtl/key_scan_pkg.sv
// key_scan_pkg: default parameters and stability counter width for the key scanner
package key_scan_pkg;
    localparam int N_KEYS_DEF = 4;
    localparam int FDIV_N_DEF = 10;
    localparam int STABLE_DEF = 3;
    localparam int CNT_W      = 3;
endpackage

// File: rtl/key_scan_if.sv
// key_scan_if: raw keys in, debounced levels and the key event handshake out
interface key_scan_if #(
    parameter int N_KEYS = 4
);
    localparam int KW = $clog2(N_KEYS);
    logic [N_KEYS-1:0] keys_in;
    logic [N_KEYS-1:0] key_state;
    logic              evt_valid;
    logic              evt_ready;
    logic [KW-1:0]     evt_key;
    logic              evt_press;
    logic              overrun;
    modport master (
        input  keys_in, evt_ready,
        output key_state, evt_valid, evt_key, evt_press, overrun
    );
    modport slave (
        output keys_in, evt_ready,
        input  key_state, evt_valid, evt_key, evt_press, overrun
    );
endinterface

// File: rtl/key_scan_rr_arbiter.sv
// rr_arbiter: picks the first requester after the last granted index, wrapping
module rr_arbiter #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] grant,
    output logic         any
);
    logic [W-1:0] j;
    // Scan offsets from farthest to nearest so the nearest requester wins
    always_comb begin
        grant = '0;
        j = '0;
        any = |req;
        for (int i = N; i >= 1; i--) begin
            j = W'((int'(last) + i) % N);
            if (req[j]) grant = j;
        end
    end
endmodule

// File: rtl/key_scan.sv
// key_scan: time-multiplexed key debouncer with one pending event per key
module key_scan import key_scan_pkg::*; #(
    parameter int N_KEYS = N_KEYS_DEF,
    parameter int FDIV_N = FDIV_N_DEF,
    parameter int STABLE = STABLE_DEF
) (
    input logic       clk,
    input logic       clrn,
    key_scan_if.master bus
);
    localparam int W = $clog2(N_KEYS);
    logic [FDIV_N-1:0]             pre;
    logic [W-1:0]                  ptr, last, gnt, evt_key;
    logic [N_KEYS-1:0][CNT_W-1:0]  cnt;
    logic [N_KEYS-1:0]             state, pend, ptype;
    logic [CNT_W-1:0]              nxt;
    logic evt_valid, evt_press, ovr, tick, diff, post, ld, any, take;
    assign tick = &pre;
    assign diff = bus.keys_in[ptr] != state[ptr];
    assign nxt  = cnt[ptr] + 1'b1;
    assign post = tick && diff && nxt == CNT_W'(STABLE);
    assign ld   = !evt_valid || bus.evt_ready;
    assign take = ld && any;
    rr_arbiter #(.N(N_KEYS)) u_arb (
        .req   (pend),
        .last  (last),
        .grant (gnt),
        .any   (any)
    );
    // A grant and a new edge on one key in the same cycle: the old type leaves, the new one stays pending
    always_ff @(posedge clk) begin
        if (!clrn) begin
            pre       <= '0;
            ptr       <= '0;
            cnt       <= '0;
            state     <= '0;
            pend      <= '0;
            ptype     <= '0;
            last      <= W'(N_KEYS - 1);
            evt_valid <= 1'b0;
            evt_key   <= '0;
            evt_press <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            pre <= pre + 1'b1;
            if (tick) begin
                ptr      <= (ptr == W'(N_KEYS - 1)) ? '0 : ptr + 1'b1;
                cnt[ptr] <= (diff && !post) ? nxt : '0;
            end
            if (ld) begin
                evt_valid <= any;
                if (any) begin
                    evt_key   <= gnt;
                    evt_press <= ptype[gnt];
                    last      <= gnt;
                end
            end
            if (take) pend[gnt] <= 1'b0;
            if (post) begin
                state[ptr] <= ~state[ptr];
                pend[ptr]  <= 1'b1;
                ptype[ptr] <= ~state[ptr];
                if (pend[ptr] && !(take && gnt == ptr)) ovr <= 1'b1;
            end
        end
    end
    assign bus.key_state = state;
    assign bus.evt_valid = evt_valid;
    assign bus.evt_key   = evt_key;
    assign bus.evt_press = evt_press;
    assign bus.overrun   = ovr;
endmodule

// File: tb/tb_key_scan.sv
// tb_key_scan: directed checks of debounce timing, event order, overrun and reset
module tb_key_scan;
    logic clk = 1'b0;
    logic clrn = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    key_scan_if #(.N_KEYS(4)) bus ();
    key_scan #(.N_KEYS(4), .FDIV_N(2), .STABLE(3)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus.master)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask
    // Edge counts in comments are rising edges after the last reset edge
    task automatic rst(input logic [3:0] k);
        @(negedge clk);
        clrn = 1'b0;
        bus.keys_in = k;
        bus.evt_ready = 1'b0;
        cyc(1);
        clrn = 1'b1;
    endtask
    task automatic evt(input string tag, input logic v, input logic [1:0] k, input logic p);
        chk({tag, "_valid"}, bus.evt_valid, v);
        if (v) begin
            chk({tag, "_key"}, bus.evt_key, k);
            chk({tag, "_press"}, bus.evt_press, p);
        end
    endtask
    initial begin
        bus.keys_in = '0;
        bus.evt_ready = 1'b0;
        // key 2 held from reset: visits at 12, 28, 44
        rst(4'b0100);
        chk("rst_state", bus.key_state, 4'b0000);
        chk("rst_valid", bus.evt_valid, 1'b0);
        chk("rst_key", bus.evt_key, 2'd0);
        chk("rst_press", bus.evt_press, 1'b0);
        chk("rst_ovr", bus.overrun, 1'b0);
        cyc(43);
        chk("k2_before", bus.key_state, 4'b0000);
        cyc(1);
        chk("k2_state", bus.key_state, 4'b0100);
        chk("k2_novalid", bus.evt_valid, 1'b0);
        cyc(1);
        evt("k2_evt", 1'b1, 2'd2, 1'b1);
        bus.evt_ready = 1'b1;
        cyc(1);
        evt("k2_drained", 1'b0, 2'd0, 1'b0);
        // key 1 glitches: first covers visit 8, second covers visits 40 and 56
        rst(4'b0000);
        cyc(2);
        bus.keys_in = 4'b0010;
        cyc(20);
        bus.keys_in = 4'b0000;
        cyc(8);
        bus.keys_in = 4'b0010;
        cyc(32);
        bus.keys_in = 4'b0000;
        cyc(18);
        chk("glitch_state", bus.key_state, 4'b0000);
        chk("glitch_valid", bus.evt_valid, 1'b0);
        chk("glitch_ovr", bus.overrun, 1'b0);
        // keys 0 and 3: key 0 at 36, key 3 at 48, key 0 released at 84
        rst(4'b1001);
        cyc(37);
        evt("k0_evt", 1'b1, 2'd0, 1'b1);
        bus.keys_in = 4'b1000;
        cyc(12);
        chk("k03_state", bus.key_state, 4'b1001);
        evt("k0_hold", 1'b1, 2'd0, 1'b1);
        cyc(41);
        chk("k0rel_state", bus.key_state, 4'b1000);
        evt("k0_hold2", 1'b1, 2'd0, 1'b1);
        chk("rr_ovr", bus.overrun, 1'b0);
        bus.evt_ready = 1'b1;
        cyc(1);
        evt("rr_first", 1'b1, 2'd3, 1'b1);
        cyc(1);
        evt("rr_second", 1'b1, 2'd0, 1'b0);
        cyc(1);
        evt("rr_done", 1'b0, 2'd0, 1'b0);
        // key 2 fills output at 45; key 0 press at 52 then release at 100
        rst(4'b0100);
        cyc(5);
        bus.keys_in = 4'b0101;
        cyc(47);
        evt("ovr_out", 1'b1, 2'd2, 1'b1);
        chk("ovr_state", bus.key_state, 4'b0101);
        chk("ovr_pre", bus.overrun, 1'b0);
        bus.keys_in = 4'b0100;
        cyc(48);
        chk("ovr_set", bus.overrun, 1'b1);
        evt("ovr_hold", 1'b1, 2'd2, 1'b1);
        bus.evt_ready = 1'b1;
        cyc(1);
        evt("ovr_rel", 1'b1, 2'd0, 1'b0);
        chk("ovr_sticky", bus.overrun, 1'b1);
        cyc(1);
        evt("ovr_single", 1'b0, 2'd0, 1'b0);
        // key 1 in output and key 3 two visits in when reset pulses at 45
        rst(4'b1010);
        chk("rst2_ovr", bus.overrun, 1'b0);
        cyc(45);
        evt("k1_evt", 1'b1, 2'd1, 1'b1);
        chk("k1_state", bus.key_state, 4'b0010);
        clrn = 1'b0;
        bus.keys_in = 4'b1000;
        cyc(1);
        clrn = 1'b1;
        chk("pulse_state", bus.key_state, 4'b0000);
        chk("pulse_valid", bus.evt_valid, 1'b0);
        chk("pulse_key", bus.evt_key, 2'd0);
        chk("pulse_press", bus.evt_press, 1'b0);
        cyc(20);
        chk("pulse_cnt", bus.key_state, 4'b0000);
        chk("pulse_noevt", bus.evt_valid, 1'b0);
        cyc(29);
        chk("k3_state", bus.key_state, 4'b1000);
        evt("k3_evt", 1'b1, 2'd3, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
